fwd_sel_ctrl: RTL and testbench
===============================

// Module: fwd_sel_ctrl
// PURPOSE
//  Forwarding/hazard controller that drives the 2-bit select of the EX-stage 4:1 operand muxes.
//  Tracks destination registers of in-flight instructions (EX, MEM, WB), registers per-operand
//  selects as each instruction enters EX, and raises a 1-cycle load-use stall when needed.
//  Sits between decode (ID) and the EX operand muxes of the 16-bit pipelined datapath.
// PARAMETERS
//  REG_ADDR_W   3  register-address width (8 GPRs)
//  ZERO_REG_EN  1  1: R0 is hardwired zero, never forwarded or matched
// PORTS
//  clk             in   1           clock, all state on rising edge
//  rst_n           in   1           synchronous reset, active-low
//  id_valid        in   1           ID holds a real instruction
//  id_rs1          in   REG_ADDR_W  source reg A
//  id_rs1_used     in   1           instruction reads rs1
//  id_rs2          in   REG_ADDR_W  source reg B
//  id_rs2_used     in   1           instruction reads rs2
//  id_rd           in   REG_ADDR_W  destination reg
//  id_reg_write    in   1           instruction writes rd
//  id_is_load      in   1           instruction is a load (data ready end of MEM)
//  pipe_hold       in   1           global freeze (memory wait); all state holds
//  flush           in   1           kill ID instruction (taken branch); EX gets bubble
//  fwd_sel_a       out  2           operand-A mux select for instruction in EX
//  fwd_sel_b       out  2           operand-B mux select for instruction in EX
//  load_use_stall  out  1           combinational; hold PC/IF/ID, bubble into EX
//  ex_valid        out  1           EX slot holds a real instruction
// BEHAVIOUR
//  - Select codes: 00 regfile, 01 EX/MEM ALU result, 10 MEM/WB result, 11 WB-retire buffer.
//  - Reset (rst_n=0 at edge): EX/MEM/WB valid=0, fwd_sel_a=fwd_sel_b=00, ex_valid=0.
//  - State: EX{v,rd,wr,ld}, MEM{v,rd,wr}, WB{v,rd,wr}. pipe_hold=1: every register holds,
//    including selects; flush ignored that cycle (upstream keeps flush high until hold drops).
//  - Advance (pipe_hold=0): MEM<=EX, WB<=MEM; EX<=ID info if id_valid & !flush & !load_use_stall,
//    else bubble (v=0). ex_valid = EX.v.
//  - match(stage,rs,used) = stage.v & stage.wr & used & stage.rd==rs & !(ZERO_REG_EN & rs==0).
//  - Select regs load on advance, evaluated against pre-edge state (stage about to shift):
//    match(EX)->01, else match(MEM)->10, else match(WB)->11, else 00; nearest stage wins.
//    Bubble entering EX -> both selects 00. Latency: select valid the cycle the instr is in EX.
//  - load_use_stall = id_valid & !flush & EX.v & EX.ld & EX.wr &
//    (match(EX,id_rs1,id_rs1_used) | match(EX,id_rs2,id_rs2_used)). Asserted regardless of
//    pipe_hold; lasts exactly 1 advancing cycle (load moves to MEM, later forwarded via 10).
//  - flush & stall same cycle: flush wins, stall=0, bubble inserted.
//  - Load in MEM/WB is forwarded normally (no stall); rd==0 writes never forwarded if ZERO_REG_EN.
//  - Reset mid-sequence discards all tracking; first post-reset instruction selects 00.
// STRUCTURE
//  - Shared package fwd_pkg: REG_ADDR_W, FWD_RF=2'b00, FWD_EXMEM=2'b01, FWD_MEMWB=2'b10,
//    FWD_WBRET=2'b11, stage-tag struct {v,rd,wr,ld}.
//  - Sub-module fwd_match_prio: combinational 3-stage compare + priority encode for one operand;
//    instantiated twice (A, B). Top holds stage registers, stall logic, select registers.
// TESTING
//  1 Reset: rst_n=0 two cycles -> sel_a=sel_b=00, stall=0, ex_valid=0; outputs stay 00 with id_valid=0.
//  2 Distance: ADD rd=1 then instrs with rs1=1 at distance 1/2/3/4 -> sel_a=01/10/11/00 in EX.
//  3 Load-use: LW rd=3, next ADD rs2=3 -> stall=1 one cycle, ex_valid=0 bubble, ADD in EX sel_b=10.
//  4 R0 + priority: write rd=0 then rs1=0 -> sel_a=00; rd=2 three times in a row, then rs1=2 -> 01.
//  5 Hold/flush: pipe_hold=1 three cycles mid-sequence -> all outputs frozen; flush with pending
//    load-use -> stall=0, next ex_valid=0, sels 00.
//  6 Both operands: rs1=rs2=5 after rd=5 writer at distance 2 -> sel_a=sel_b=10; rs_used=0 -> 00.

Source files
------------

// File: rtl/fwd_pkg.sv
// Shared definitions for the EX-stage operand forwarding controller:
// select encodings and the per-stage destination tags.
package fwd_pkg;

    localparam int unsigned REG_ADDR_W = 3;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;
    localparam logic [1:0] FWD_WBRET = 2'b11;

    typedef struct packed {
        logic                  v;
        logic [REG_ADDR_W-1:0] rd;
        logic                  wr;
        logic                  ld;
    } stage_tag_t;

    // MEM and WB never need the load flag: loads there forward without stalling.
    typedef struct packed {
        logic                  v;
        logic [REG_ADDR_W-1:0] rd;
        logic                  wr;
    } fwd_tag_t;

endpackage

// File: rtl/fwd_match_prio.sv
// Compares one source operand against the EX/MEM/WB destination tags and
// picks the forwarding select; the nearest producing stage wins.
module fwd_match_prio #(
    parameter int unsigned REG_ADDR_W  = fwd_pkg::REG_ADDR_W,
    parameter bit          ZERO_REG_EN = 1'b1
) (
    input  logic [REG_ADDR_W-1:0] rs,
    input  logic                  used,
    input  logic                  ex_v,
    input  logic                  ex_wr,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  mem_v,
    input  logic                  mem_wr,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic                  wb_v,
    input  logic                  wb_wr,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    output logic                  hit_ex,
    output logic [1:0]            sel
);
    import fwd_pkg::*;

    logic rs_zero;
    logic hit_mem;
    logic hit_wb;

    always_comb begin
        rs_zero = ZERO_REG_EN && (rs == '0);
        hit_ex  = ex_v  & ex_wr  & used & (ex_rd  == rs) & !rs_zero;
        hit_mem = mem_v & mem_wr & used & (mem_rd == rs) & !rs_zero;
        hit_wb  = wb_v  & wb_wr  & used & (wb_rd  == rs) & !rs_zero;

        sel = FWD_RF;
        if (hit_ex)       sel = FWD_EXMEM;
        else if (hit_mem) sel = FWD_MEMWB;
        else if (hit_wb)  sel = FWD_WBRET;
    end

endmodule

// File: rtl/fwd_sel_ctrl.sv
// Forwarding/hazard controller: tracks in-flight destinations, registers the
// EX operand-mux selects as each instruction enters EX, and flags load-use stalls.
module fwd_sel_ctrl #(
    parameter int unsigned REG_ADDR_W  = fwd_pkg::REG_ADDR_W,
    parameter bit          ZERO_REG_EN = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic                  id_rs1_used,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_rs2_used,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_reg_write,
    input  logic                  id_is_load,
    input  logic                  pipe_hold,
    input  logic                  flush,
    output logic [1:0]            fwd_sel_a,
    output logic [1:0]            fwd_sel_b,
    output logic                  load_use_stall,
    output logic                  ex_valid
);
    import fwd_pkg::*;

    stage_tag_t ex_q;
    fwd_tag_t   mem_q;
    fwd_tag_t   wb_q;

    logic [1:0] sel_a_nxt;
    logic [1:0] sel_b_nxt;
    logic       hit_ex_a;
    logic       hit_ex_b;
    logic       issue;

    fwd_match_prio #(
        .REG_ADDR_W (REG_ADDR_W),
        .ZERO_REG_EN(ZERO_REG_EN)
    ) u_prio_a (
        .rs    (id_rs1),
        .used  (id_rs1_used),
        .ex_v  (ex_q.v),
        .ex_wr (ex_q.wr),
        .ex_rd (ex_q.rd),
        .mem_v (mem_q.v),
        .mem_wr(mem_q.wr),
        .mem_rd(mem_q.rd),
        .wb_v  (wb_q.v),
        .wb_wr (wb_q.wr),
        .wb_rd (wb_q.rd),
        .hit_ex(hit_ex_a),
        .sel   (sel_a_nxt)
    );

    fwd_match_prio #(
        .REG_ADDR_W (REG_ADDR_W),
        .ZERO_REG_EN(ZERO_REG_EN)
    ) u_prio_b (
        .rs    (id_rs2),
        .used  (id_rs2_used),
        .ex_v  (ex_q.v),
        .ex_wr (ex_q.wr),
        .ex_rd (ex_q.rd),
        .mem_v (mem_q.v),
        .mem_wr(mem_q.wr),
        .mem_rd(mem_q.rd),
        .wb_v  (wb_q.v),
        .wb_wr (wb_q.wr),
        .wb_rd (wb_q.rd),
        .hit_ex(hit_ex_b),
        .sel   (sel_b_nxt)
    );

    // Stall depends only on ID and EX contents, so it stays visible while frozen.
    always_comb begin
        load_use_stall = id_valid & !flush & ex_q.v & ex_q.ld & ex_q.wr &
                         (hit_ex_a | hit_ex_b);
        issue          = id_valid & !flush & !load_use_stall;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_q      <= '0;
            mem_q     <= '0;
            wb_q      <= '0;
            fwd_sel_a <= FWD_RF;
            fwd_sel_b <= FWD_RF;
        end else if (!pipe_hold) begin
            mem_q <= '{v: ex_q.v, rd: ex_q.rd, wr: ex_q.wr};
            wb_q  <= mem_q;
            if (issue) begin
                ex_q      <= '{v: 1'b1, rd: id_rd, wr: id_reg_write, ld: id_is_load};
                fwd_sel_a <= sel_a_nxt;
                fwd_sel_b <= sel_b_nxt;
            end else begin
                ex_q      <= '0;
                fwd_sel_a <= FWD_RF;
                fwd_sel_b <= FWD_RF;
            end
        end
    end

    assign ex_valid = ex_q.v;

endmodule

// File: tb/tb_fwd_sel_ctrl.sv
// Directed bench for fwd_sel_ctrl: each task drives a scenario and checks
// selects, stall and ex_valid against hand-derived values.
module tb_fwd_sel_ctrl;

    logic       clk;
    logic       rst_n;
    logic       id_valid;
    logic [2:0] id_rs1;
    logic       id_rs1_used;
    logic [2:0] id_rs2;
    logic       id_rs2_used;
    logic [2:0] id_rd;
    logic       id_reg_write;
    logic       id_is_load;
    logic       pipe_hold;
    logic       flush;
    logic [1:0] fwd_sel_a;
    logic [1:0] fwd_sel_b;
    logic       load_use_stall;
    logic       ex_valid;

    int errors = 0;
    int checks = 0;

    fwd_sel_ctrl #(
        .REG_ADDR_W (3),
        .ZERO_REG_EN(1'b1)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .id_valid      (id_valid),
        .id_rs1        (id_rs1),
        .id_rs1_used   (id_rs1_used),
        .id_rs2        (id_rs2),
        .id_rs2_used   (id_rs2_used),
        .id_rd         (id_rd),
        .id_reg_write  (id_reg_write),
        .id_is_load    (id_is_load),
        .pipe_hold     (pipe_hold),
        .flush         (flush),
        .fwd_sel_a     (fwd_sel_a),
        .fwd_sel_b     (fwd_sel_b),
        .load_use_stall(load_use_stall),
        .ex_valid      (ex_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one instruction in ID (inputs only; no clock edge).
    task automatic put(input logic v, input logic [2:0] rs1, input logic u1,
                       input logic [2:0] rs2, input logic u2,
                       input logic [2:0] rd, input logic wr, input logic ld);
        id_valid     = v;
        id_rs1       = rs1;
        id_rs1_used  = u1;
        id_rs2       = rs2;
        id_rs2_used  = u2;
        id_rd        = rd;
        id_reg_write = wr;
        id_is_load   = ld;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        put(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
        repeat (4) step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        pipe_hold = 1'b0;
        flush = 1'b0;
        put(1'b1, 3'd1, 1'b1, 3'd2, 1'b1, 3'd3, 1'b1, 1'b0);
        step();
        step();
        checks++;
        if ({fwd_sel_a, fwd_sel_b, load_use_stall, ex_valid} !== 6'b0000_00) begin
            errors++;
            $display("FAIL reset_state sel_a=%b sel_b=%b stall=%b exv=%b expected 00 00 0 0",
                     fwd_sel_a, fwd_sel_b, load_use_stall, ex_valid);
        end
        rst_n = 1'b1;
        put(1'b0, 3'd1, 1'b1, 3'd2, 1'b1, 3'd3, 1'b1, 1'b0);
        step();
        step();
        checks++;
        if ({fwd_sel_a, fwd_sel_b, ex_valid} !== 5'b0000_0) begin
            errors++;
            $display("FAIL idle_after_reset sel_a=%b sel_b=%b exv=%b expected 00 00 0",
                     fwd_sel_a, fwd_sel_b, ex_valid);
        end
    endtask

    task automatic test_distance();
        logic [1:0] exp_sel [1:4];
        exp_sel[1] = 2'b01;
        exp_sel[2] = 2'b10;
        exp_sel[3] = 2'b11;
        exp_sel[4] = 2'b00;
        drain();
        for (int d = 1; d <= 4; d++) begin
            put(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd1, 1'b1, 1'b0);
            step();
            for (int k = 1; k < d; k++) begin
                put(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
                step();
            end
            put(1'b1, 3'd1, 1'b1, 3'd0, 1'b0, 3'd7, 1'b0, 1'b0);
            step();
            checks++;
            if (fwd_sel_a !== exp_sel[d] || ex_valid !== 1'b1) begin
                errors++;
                $display("FAIL distance_%0d sel_a=%b exv=%b expected %b 1",
                         d, fwd_sel_a, ex_valid, exp_sel[d]);
            end
        end
    endtask

    task automatic test_load_use();
        drain();
        put(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd3, 1'b1, 1'b1);
        step();
        put(1'b1, 3'd0, 1'b0, 3'd3, 1'b1, 3'd4, 1'b1, 1'b0);
        checks++;
        if (load_use_stall !== 1'b1) begin
            errors++;
            $display("FAIL load_use_stall_on stall=%b expected 1", load_use_stall);
        end
        step();
        checks++;
        if (ex_valid !== 1'b0 || load_use_stall !== 1'b0) begin
            errors++;
            $display("FAIL load_use_bubble exv=%b stall=%b expected 0 0", ex_valid, load_use_stall);
        end
        step();
        checks++;
        if (ex_valid !== 1'b1 || fwd_sel_b !== 2'b10 || fwd_sel_a !== 2'b00) begin
            errors++;
            $display("FAIL load_use_fwd exv=%b sel_a=%b sel_b=%b expected 1 00 10",
                     ex_valid, fwd_sel_a, fwd_sel_b);
        end
    endtask

    task automatic test_r0_priority();
        drain();
        put(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b1, 1'b0);
        step();
        put(1'b1, 3'd0, 1'b1, 3'd0, 1'b0, 3'd6, 1'b0, 1'b0);
        step();
        checks++;
        if (fwd_sel_a !== 2'b00 || ex_valid !== 1'b1) begin
            errors++;
            $display("FAIL r0_not_forwarded sel_a=%b exv=%b expected 00 1", fwd_sel_a, ex_valid);
        end
        repeat (3) begin
            put(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd2, 1'b1, 1'b0);
            step();
        end
        put(1'b1, 3'd2, 1'b1, 3'd0, 1'b0, 3'd6, 1'b0, 1'b0);
        step();
        checks++;
        if (fwd_sel_a !== 2'b01) begin
            errors++;
            $display("FAIL nearest_wins sel_a=%b expected 01", fwd_sel_a);
        end
    endtask

    task automatic test_hold_flush();
        drain();
        put(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd4, 1'b1, 1'b0);
        step();
        put(1'b1, 3'd4, 1'b1, 3'd0, 1'b0, 3'd6, 1'b0, 1'b0);
        step();
        checks++;
        if (fwd_sel_a !== 2'b01 || ex_valid !== 1'b1) begin
            errors++;
            $display("FAIL pre_hold sel_a=%b exv=%b expected 01 1", fwd_sel_a, ex_valid);
        end
        pipe_hold = 1'b1;
        put(1'b1, 3'd4, 1'b1, 3'd0, 1'b0, 3'd6, 1'b0, 1'b0);
        for (int c = 1; c <= 3; c++) begin
            step();
            checks++;
            if (fwd_sel_a !== 2'b01 || fwd_sel_b !== 2'b00 || ex_valid !== 1'b1) begin
                errors++;
                $display("FAIL hold_cycle_%0d sel_a=%b sel_b=%b exv=%b expected 01 00 1",
                         c, fwd_sel_a, fwd_sel_b, ex_valid);
            end
        end
        pipe_hold = 1'b0;
        step();
        checks++;
        if (fwd_sel_a !== 2'b10 || ex_valid !== 1'b1) begin
            errors++;
            $display("FAIL post_hold sel_a=%b exv=%b expected 10 1", fwd_sel_a, ex_valid);
        end

        drain();
        put(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd6, 1'b1, 1'b1);
        step();
        pipe_hold = 1'b1;
        put(1'b1, 3'd6, 1'b1, 3'd0, 1'b0, 3'd5, 1'b1, 1'b0);
        checks++;
        if (load_use_stall !== 1'b1) begin
            errors++;
            $display("FAIL stall_during_hold stall=%b expected 1", load_use_stall);
        end
        step();
        pipe_hold = 1'b0;
        flush = 1'b1;
        #1;
        checks++;
        if (load_use_stall !== 1'b0 || ex_valid !== 1'b1) begin
            errors++;
            $display("FAIL flush_kills_stall stall=%b exv=%b expected 0 1", load_use_stall, ex_valid);
        end
        step();
        flush = 1'b0;
        checks++;
        if (ex_valid !== 1'b0 || fwd_sel_a !== 2'b00 || fwd_sel_b !== 2'b00) begin
            errors++;
            $display("FAIL flush_bubble exv=%b sel_a=%b sel_b=%b expected 0 00 00",
                     ex_valid, fwd_sel_a, fwd_sel_b);
        end
    endtask

    task automatic test_both_operands();
        drain();
        put(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd5, 1'b1, 1'b0);
        step();
        put(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
        step();
        put(1'b1, 3'd5, 1'b1, 3'd5, 1'b1, 3'd6, 1'b0, 1'b0);
        step();
        checks++;
        if (fwd_sel_a !== 2'b10 || fwd_sel_b !== 2'b10) begin
            errors++;
            $display("FAIL both_ops sel_a=%b sel_b=%b expected 10 10", fwd_sel_a, fwd_sel_b);
        end
        put(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd5, 1'b1, 1'b0);
        step();
        put(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
        step();
        put(1'b1, 3'd5, 1'b0, 3'd5, 1'b0, 3'd6, 1'b0, 1'b0);
        step();
        checks++;
        if (fwd_sel_a !== 2'b00 || fwd_sel_b !== 2'b00 || ex_valid !== 1'b1) begin
            errors++;
            $display("FAIL unused_ops sel_a=%b sel_b=%b exv=%b expected 00 00 1",
                     fwd_sel_a, fwd_sel_b, ex_valid);
        end
    endtask

    task automatic test_reset_mid();
        drain();
        put(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd1, 1'b1, 1'b0);
        step();
        rst_n = 1'b0;
        put(1'b1, 3'd1, 1'b1, 3'd0, 1'b0, 3'd2, 1'b0, 1'b0);
        step();
        rst_n = 1'b1;
        put(1'b1, 3'd1, 1'b1, 3'd1, 1'b1, 3'd2, 1'b0, 1'b0);
        step();
        checks++;
        if (fwd_sel_a !== 2'b00 || fwd_sel_b !== 2'b00 || ex_valid !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid sel_a=%b sel_b=%b exv=%b expected 00 00 1",
                     fwd_sel_a, fwd_sel_b, ex_valid);
        end
    endtask

    initial begin
        test_reset();
        test_distance();
        test_load_use();
        test_r0_priority();
        test_hold_flush();
        test_both_operands();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
